// File: rtl/mux8_serial_ctrl.sv
// Parallel-to-serial control stage for an external 8:1 bit mux: latches a word,
// steps the select 0..7 and registers the mux output. Optional parity bit: MUX8_SERIAL_PARITY_EN.
module mux8_serial_ctrl #(
    parameter int TICK_DIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] din,
    output logic [2:0] s,
    input  logic       y,
    output logic       ser_out,
    output logic       ser_valid,
    output logic       busy,
    output logic       done
);

    // state  | meaning
    // IDLE   | waiting for a word, in_ready high
    // SHIFT  | select stepping 0..7, one bit period per value
    // PARITY | extra bit period carrying ^din (parity build only)
    localparam int CW = $clog2(TICK_DIV) + 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

`ifdef MUX8_SERIAL_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [7:0]    din_nx;
    logic [2:0]    s_nx;
    logic          done_nx;
    logic          sample;
    logic          period_end;

    assign in_ready   = (state == IDLE) && !rst;
    assign busy       = (state != IDLE);
    assign period_end = (cnt == LAST);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        din_nx   = din;
        s_nx     = s;
        done_nx  = 1'b0;
        sample   = y;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    din_nx   = data_in;
                    s_nx     = 3'd0;
                    cnt_nx   = '0;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (period_end) begin
                    cnt_nx = '0;
                    if (s != 3'd7) begin
                        s_nx = s + 3'd1;
                    end else begin
`ifdef MUX8_SERIAL_PARITY_EN
                        state_nx = PARITY;
`else
                        state_nx = IDLE;
                        done_nx  = 1'b1;
`endif
                    end
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
`ifdef MUX8_SERIAL_PARITY_EN
            PARITY: begin
                // select stays at 7; the sampled bit is replaced by even parity
                sample = ^din;
                if (period_end) begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            din       <= 8'd0;
            s         <= 3'd0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            din       <= din_nx;
            s         <= s_nx;
            ser_out   <= sample;
            ser_valid <= busy && (cnt == '0);
            done      <= done_nx;
        end
    end

endmodule

// File: tb/tb_mux8_serial_ctrl.sv
// Directed bench for mux8_serial_ctrl: one instance at TICK_DIV=1, one at TICK_DIV=4,
// each with a behavioural 8:1 mux closing the loop.
module tb_mux8_serial_ctrl;

`ifdef MUX8_SERIAL_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       valid1, valid4;
    logic       cur_d4;

    logic       in_ready1, ser_out1, ser_valid1, busy1, done1, y1;
    logic [7:0] din1;
    logic [2:0] s1;
    logic       in_ready4, ser_out4, ser_valid4, busy4, done4, y4;
    logic [7:0] din4;
    logic [2:0] s4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign y1 = din1[s1];
    assign y4 = din4[s4];

    mux8_serial_ctrl #(.TICK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .data_in(data_in), .in_valid(valid1), .in_ready(in_ready1),
        .din(din1), .s(s1), .y(y1), .ser_out(ser_out1), .ser_valid(ser_valid1),
        .busy(busy1), .done(done1)
    );

    mux8_serial_ctrl #(.TICK_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .data_in(data_in), .in_valid(valid4), .in_ready(in_ready4),
        .din(din4), .s(s4), .y(y4), .ser_out(ser_out4), .ser_valid(ser_valid4),
        .busy(busy4), .done(done4)
    );

    logic       m_in_ready, m_ser_out, m_ser_valid, m_busy, m_done;
    logic [7:0] m_din;
    logic [2:0] m_s;
    assign m_in_ready  = cur_d4 ? in_ready4  : in_ready1;
    assign m_ser_out   = cur_d4 ? ser_out4   : ser_out1;
    assign m_ser_valid = cur_d4 ? ser_valid4 : ser_valid1;
    assign m_busy      = cur_d4 ? busy4      : busy1;
    assign m_done      = cur_d4 ? done4      : done1;
    assign m_din       = cur_d4 ? din4       : din1;
    assign m_s         = cur_d4 ? s4         : s1;

    typedef struct {
        logic       d4;      // 1: TICK_DIV=4 instance
        logic [7:0] data;
        logic [7:0] exp_seq; // exp_seq[k] is the bit expected on strobe k
        logic       exp_par; // ninth strobe value in the parity build
        logic       hold;    // keep in_valid high through the word
        logic       toggle;  // invert data_in every cycle while busy
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic run_word(input vec_t v);
        int d, nbits, last, k, es;
        logic exp_sv, exp_busy;
        d     = v.d4 ? 4 : 1;
        nbits = 8 + PAR;
        last  = 1 + nbits * d;
        cur_d4  = v.d4;
        data_in = v.data;
        if (v.d4) valid4 = 1'b1; else valid1 = 1'b1;
        #1;
        chk("in_ready_pre", m_in_ready, 1);
        @(posedge clk); #1;
        if (!v.hold) begin
            valid1 = 1'b0;
            valid4 = 1'b0;
        end
        for (int c = 1; c <= last; c++) begin
            exp_busy = (c <= nbits * d);
            exp_sv   = (c >= 2) && (c <= 2 + (nbits - 1) * d) && (((c - 2) % d) == 0);
            chk("busy", m_busy, exp_busy);
            chk("in_ready", m_in_ready, !exp_busy);
            chk("done", m_done, c == last);
            chk("ser_valid", m_ser_valid, exp_sv);
            if (exp_sv) begin
                k = (c - 2) / d;
                chk("ser_out", m_ser_out, (k < 8) ? v.exp_seq[k] : v.exp_par);
            end
            if (exp_busy) begin
                chk("din", m_din, v.data);
                es = (c - 1) / d;
                if (es > 7) es = 7;
                chk("s", m_s, es);
            end
            if (v.toggle) data_in = ~data_in;
            if (c < last) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        vecs[0] = '{d4:1'b0, data:8'hA5, exp_seq:8'hA5, exp_par:1'b0, hold:1'b0, toggle:1'b0};
        vecs[1] = '{d4:1'b1, data:8'h01, exp_seq:8'h01, exp_par:1'b1, hold:1'b0, toggle:1'b0};
        vecs[2] = '{d4:1'b0, data:8'hFF, exp_seq:8'hFF, exp_par:1'b0, hold:1'b1, toggle:1'b0};
        vecs[3] = '{d4:1'b0, data:8'h00, exp_seq:8'h00, exp_par:1'b0, hold:1'b0, toggle:1'b0};
        vecs[4] = '{d4:1'b0, data:8'h07, exp_seq:8'h07, exp_par:1'b1, hold:1'b0, toggle:1'b0};
        vecs[5] = '{d4:1'b0, data:8'h03, exp_seq:8'h03, exp_par:1'b0, hold:1'b0, toggle:1'b0};
        vecs[6] = '{d4:1'b0, data:8'h5A, exp_seq:8'h5A, exp_par:1'b0, hold:1'b0, toggle:1'b1};
        vecs[7] = '{d4:1'b1, data:8'hC6, exp_seq:8'hC6, exp_par:1'b0, hold:1'b0, toggle:1'b1};

        rst = 1'b1; data_in = 8'h00; valid1 = 1'b0; valid4 = 1'b0; cur_d4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready1", in_ready1, 0);
        chk("rst_in_ready4", in_ready4, 0);
        rst = 1'b0;
        #1;
        chk("rel_in_ready1", in_ready1, 1);
        chk("rel_in_ready4", in_ready4, 1);
        chk("rel_outs1", {din1, s1, ser_out1, ser_valid1, busy1, done1}, 0);
        chk("rel_outs4", {din4, s4, ser_out4, ser_valid4, busy4, done4}, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run_word(vecs[i]);

        // reset in cycle 5 of a word: outputs clear at once, word is dropped
        cur_d4 = 1'b0; data_in = 8'h3C; valid1 = 1'b1;
        @(posedge clk); #1;
        valid1 = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("mid_busy_before", busy1, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_outs", {din1, s1, ser_out1, ser_valid1, busy1, done1}, 0);
        chk("mid_rst_in_ready", in_ready1, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("mid_rel_in_ready", in_ready1, 1);
        for (int c = 0; c < 12; c++) begin
            chk("mid_no_done", done1, 0);
            chk("mid_no_strobe", ser_valid1, 0);
            @(posedge clk); #1;
        end
        run_word('{d4:1'b0, data:8'h81, exp_seq:8'h81, exp_par:1'b0, hold:1'b0, toggle:1'b0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
